// File: rtl/vga_glyph_fetch_if.sv
// Read-side bus to the text buffer and font memory, both with 1-cycle registered reads.
// Signal names follow the pixel generator's point of view.
interface vga_glyph_fetch_if #(
  parameter int unsigned TEXT_ADDR_WIDTH = 12,
  parameter int unsigned FONT_ADDR_WIDTH = 11
);
  logic [TEXT_ADDR_WIDTH-1:0] text_addr_o;
  logic [7:0]                 text_data_i;
  logic [FONT_ADDR_WIDTH-1:0] font_addr_o;
  logic [0:7]                 font_data_i;  // bit 0 is the leftmost pixel

  modport master (
    output text_addr_o, font_addr_o,
    input  text_data_i, font_data_i
  );

  modport slave (
    input  text_addr_o, font_addr_o,
    output text_data_i, font_data_i
  );
endinterface

// File: rtl/vga_glyph_fetch.sv
// Text-mode pixel generator: coordinates -> text cell -> glyph row -> 1-bit pixel,
// with a blinking inverse-video cursor. Fixed 5-cycle latency, no stalls.
module vga_glyph_fetch #(
  parameter int unsigned COLS            = 80,
  parameter int unsigned ROWS            = 30,
  parameter int unsigned TEXT_ADDR_WIDTH = 12,
  parameter int unsigned FONT_ADDR_WIDTH = 11,
  parameter int unsigned BLINK_FRAMES    = 30
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [9:0]               hcount_i,
  input  logic [9:0]               vcount_i,
  input  logic                     active_i,
  vga_glyph_fetch_if.master        mem,
  input  logic                     cursor_en_i,
  input  logic [6:0]               cursor_col_i,
  input  logic [4:0]               cursor_row_i,
  output logic                     pixel_o,
  output logic                     active_o
);

  localparam int unsigned CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  typedef struct packed {
    logic       v;
    logic [2:0] x;
    logic [3:0] y;
    logic       hit;
  } stage_t;

  // st_q[0..3] hold the sideband leaving S1..S4
  stage_t st_q [4];
  stage_t st_d [4];

  logic [TEXT_ADDR_WIDTH-1:0] text_addr_q, text_addr_d;
  logic [FONT_ADDR_WIDTH-1:0] font_addr_q, font_addr_d;
  logic [0:7]                 shreg_q, shreg_d;
  logic                       pixel_q, pixel_d;
  logic                       active_q, active_d;
  logic [CNT_W-1:0]           frame_cnt_q, frame_cnt_d;
  logic                       blink_q, blink_d;

  logic [4:0]                 row;
  logic [6:0]                 col;
  logic [TEXT_ADDR_WIDTH-1:0] row_base;
  logic                       cursor_hit;
  logic                       frame_start;
  logic                       load;
  logic                       pix_bit;
  logic                       unused_ok;

  assign row = vcount_i[8:4];
  assign col = hcount_i[9:3];

  if (COLS == 80) begin : g_mul80
    assign row_base = TEXT_ADDR_WIDTH'({row, 6'b0}) + TEXT_ADDR_WIDTH'({row, 4'b0});
  end else begin : g_mul
    assign row_base = TEXT_ADDR_WIDTH'(row * COLS);
  end

  assign cursor_hit  = cursor_en_i & (col == cursor_col_i) & (row == cursor_row_i)
                     & (32'(row) < ROWS);
  assign frame_start = active_i & (hcount_i == '0) & (vcount_i == '0);
  assign unused_ok   = ^{mem.text_data_i[7], vcount_i[9]};

  always_comb begin
    text_addr_d = active_i ? (row_base + TEXT_ADDR_WIDTH'(col)) : text_addr_q;

    st_d[0].v   = active_i;
    st_d[0].x   = hcount_i[2:0];
    st_d[0].y   = vcount_i[3:0];
    st_d[0].hit = cursor_hit;
    st_d[1]     = st_q[0];
    st_d[2]     = st_q[1];
    st_d[3]     = st_q[2];

    font_addr_d = st_q[1].v ? FONT_ADDR_WIDTH'({mem.text_data_i[6:0], st_q[1].y})
                            : font_addr_q;

    // Reload on x==0 or when the previous output cycle was blank, so a line
    // starting mid-character still picks the right bit from the fresh row.
    load     = (st_q[3].x == 3'd0) | ~active_q;
    pix_bit  = load ? mem.font_data_i[st_q[3].x] : shreg_q[st_q[3].x];
    shreg_d  = load ? mem.font_data_i : shreg_q;
    pixel_d  = st_q[3].v & (pix_bit ^ (st_q[3].hit & blink_q));
    active_d = st_q[3].v;

    frame_cnt_d = frame_cnt_q;
    blink_d     = blink_q;
    if (frame_start) begin
      if (frame_cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
        frame_cnt_d = '0;
        blink_d     = ~blink_q;
      end else begin
        frame_cnt_d = frame_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < 4; i++) st_q[i] <= '0;
      text_addr_q <= '0;
      font_addr_q <= '0;
      shreg_q     <= '0;
      pixel_q     <= 1'b0;
      active_q    <= 1'b0;
      frame_cnt_q <= '0;
      blink_q     <= 1'b1;
    end else begin
      st_q        <= st_d;
      text_addr_q <= text_addr_d;
      font_addr_q <= font_addr_d;
      shreg_q     <= shreg_d;
      pixel_q     <= pixel_d;
      active_q    <= active_d;
      frame_cnt_q <= frame_cnt_d;
      blink_q     <= blink_d;
    end
  end

  assign mem.text_addr_o = text_addr_q;
  assign mem.font_addr_o = font_addr_q;
  assign pixel_o         = pixel_q;
  assign active_o        = active_q;

endmodule

// File: tb/tb_vga_glyph_fetch.sv
// Directed bench for vga_glyph_fetch with registered-read text and font memory models.
module tb_vga_glyph_fetch;

  logic       clk;
  logic       rst;
  logic [9:0] hcount;
  logic [9:0] vcount;
  logic       active;
  logic       cursor_en;
  logic [6:0] cursor_col;
  logic [4:0] cursor_row;
  logic       pixel;
  logic       active_out;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] text_mem [0:4095];
  logic [0:7] font_mem [0:2047];

  vga_glyph_fetch_if #(.TEXT_ADDR_WIDTH(12), .FONT_ADDR_WIDTH(11)) mem_if ();

  vga_glyph_fetch #(
    .COLS(80), .ROWS(30), .TEXT_ADDR_WIDTH(12), .FONT_ADDR_WIDTH(11), .BLINK_FRAMES(2)
  ) dut (
    .clk_i(clk), .rst_i(rst), .hcount_i(hcount), .vcount_i(vcount), .active_i(active),
    .mem(mem_if), .cursor_en_i(cursor_en), .cursor_col_i(cursor_col),
    .cursor_row_i(cursor_row), .pixel_o(pixel), .active_o(active_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    mem_if.text_data_i <= text_mem[mem_if.text_addr_o];
    mem_if.font_data_i <= font_mem[mem_if.font_addr_o];
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives n active pixels from (h0,v) then blanks; pixel k is due 5 cycles after input k.
  task automatic run_seq(input int h0, input int n, input int v, input logic [15:0] exp_pix,
                         input int exp_ta, input int exp_fa);
    for (int t = 0; t <= n + 4; t++) begin
      if (t < n) begin
        active = 1'b1;
        hcount = 10'(h0 + t);
        vcount = 10'(v);
      end else begin
        active = 1'b0;
      end
      tick();
      if (t == 0) check_val("text_addr", 32'(mem_if.text_addr_o), 32'(exp_ta));
      if (t == 2) check_val("font_addr", 32'(mem_if.font_addr_o), 32'(exp_fa));
      if ((t - 4) >= 0 && (t - 4) < n) begin
        check_val($sformatf("act%0d", t - 4), 32'(active_out), 32'd1);
        check_val($sformatf("pix%0d", t - 4), 32'(pixel), 32'(exp_pix[t - 4]));
      end else begin
        check_val($sformatf("idle_act_t%0d", t), 32'(active_out), 32'd0);
        check_val($sformatf("idle_pix_t%0d", t), 32'(pixel), 32'd0);
      end
    end
  endtask

  task automatic frame_pulse();
    active = 1'b1;
    hcount = '0;
    vcount = '0;
    tick();
    active = 1'b0;
    repeat (5) tick();
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) text_mem[i] = 8'h00;
    for (int i = 0; i < 2048; i++) font_mem[i] = 8'h00;
    text_mem[0]    = 8'h41;
    text_mem[1]    = 8'h42;
    text_mem[163]  = 8'h43;
    font_mem[1045] = 8'b00011000;
    font_mem[1061] = 8'b10000001;
    font_mem[1072] = 8'b11111111;

    rst = 1'b1; active = 1'b0; hcount = '0; vcount = '0;
    cursor_en = 1'b0; cursor_col = 7'd3; cursor_row = 5'd2;
    repeat (2) tick();
    check_val("rst_text_addr", 32'(mem_if.text_addr_o), 32'd0);
    check_val("rst_font_addr", 32'(mem_if.font_addr_o), 32'd0);
    check_val("rst_pixel", 32'(pixel), 32'd0);
    check_val("rst_active", 32'(active_out), 32'd0);
    rst = 1'b0;

    // Address math and hold while inactive
    active = 1'b1; hcount = 10'd24; vcount = 10'd37;
    tick();
    check_val("addr_163", 32'(mem_if.text_addr_o), 32'd163);
    hcount = 10'd639; vcount = 10'd479;
    tick();
    check_val("addr_2399", 32'(mem_if.text_addr_o), 32'd2399);
    active = 1'b0;
    tick();
    check_val("addr_hold", 32'(mem_if.text_addr_o), 32'd2399);
    repeat (5) tick();

    // Glyph path: 'A' row 5, then 'A' followed by 'B'
    run_seq(0, 8, 5, 16'h0018, 0, 1045);
    run_seq(0, 16, 5, 16'b1000_0001_0001_1000, 0, 1045);

    // Blanking: outputs stay off and both addresses freeze
    for (int i = 0; i < 10; i++) begin
      tick();
      check_val("blank_text_addr", 32'(mem_if.text_addr_o), 32'd1);
      check_val("blank_font_addr", 32'(mem_if.font_addr_o), 32'd1061);
      check_val("blank_pixel", 32'(pixel), 32'd0);
      check_val("blank_active", 32'(active_out), 32'd0);
    end

    // Bit 7 of the character code is ignored
    text_mem[0] = 8'hC1;
    run_seq(0, 8, 5, 16'h0018, 0, 1045);

    // Line starting mid-character at x=5
    font_mem[1045] = 8'b00000100;
    run_seq(5, 3, 5, 16'h0001, 0, 1045);

    // Cursor blink with a 2-frame half-period, starting from a fresh reset
    rst = 1'b1; tick(); rst = 1'b0;
    cursor_en = 1'b1;
    run_seq(24, 8, 32, 16'h0000, 163, 1072);
    frame_pulse();
    run_seq(24, 8, 32, 16'h0000, 163, 1072);
    frame_pulse();
    run_seq(24, 8, 32, 16'h00FF, 163, 1072);
    frame_pulse();
    run_seq(24, 8, 32, 16'h00FF, 163, 1072);
    frame_pulse();
    cursor_en = 1'b0;
    run_seq(24, 8, 32, 16'h00FF, 163, 1072);
    cursor_en = 1'b1;
    frame_pulse();
    frame_pulse();
    run_seq(24, 8, 32, 16'h00FF, 163, 1072);

    // Reset mid-line: in-flight pixels dropped, blink phase back to visible
    for (int h = 24; h < 30; h++) begin
      active = 1'b1; hcount = 10'(h); vcount = 10'd32;
      tick();
    end
    check_val("pre_rst_active", 32'(active_out), 32'd1);
    rst = 1'b1; hcount = 10'd30;
    tick();
    check_val("mid_rst_pixel", 32'(pixel), 32'd0);
    check_val("mid_rst_active", 32'(active_out), 32'd0);
    check_val("mid_rst_text_addr", 32'(mem_if.text_addr_o), 32'd0);
    check_val("mid_rst_font_addr", 32'(mem_if.font_addr_o), 32'd0);
    rst = 1'b0;
    run_seq(24, 8, 32, 16'h0000, 163, 1072);

    // Frame start during reset is not counted
    rst = 1'b1; active = 1'b1; hcount = '0; vcount = '0;
    tick();
    rst = 1'b0; active = 1'b0;
    repeat (5) tick();
    frame_pulse();
    run_seq(24, 8, 32, 16'h0000, 163, 1072);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vga_glyph_fetch.md
# vga_glyph_fetch

Text-mode pixel generator on the read side of the font memory and the text buffer. It takes pixel coordinates from the VGA timing generator, reads the character code from the text buffer, and issues the glyph-row address to the font memory. It then serializes the returned 8-pixel row onto a 1-bit pixel stream. A blinking inverse-video cursor is overlaid on that stream. It runs in the 25 MHz pixel domain between the timing generator and the colour/DAC output stage.

## Interface
- COLS, 80: characters per text row.
- ROWS, 30: text rows per screen.
- TEXT_ADDR_WIDTH, 12: text-buffer address width (COLS*ROWS = 2400 cells).
- FONT_ADDR_WIDTH, 11: font-memory address width (128 chars x 16 rows).
- BLINK_FRAMES, 30: frames per cursor blink half-period.

- clk_i  in  1  25 MHz pixel clock.
- rst_i  in  1  Reset, synchronous, active-high.
- hcount_i  in  10  Pixel column, 0..639 while active.
- vcount_i  in  10  Pixel line, 0..479 while active.
- active_i  in  1  Visible-area flag.
- text_addr_o  out  TEXT_ADDR_WIDTH  Text-buffer read address (registered).
- text_data_i  in  8  Character code; valid 1 cycle after text_addr_o.
- font_addr_o  out  FONT_ADDR_WIDTH  Font read address {char[6:0], glyph_row[3:0]} (registered).
- font_data_i  in  [0:7]  Glyph row; bit 0 is the leftmost pixel; valid 1 cycle after font_addr_o.
- cursor_en_i  in  1  Cursor enable.
- cursor_col_i  in  7  Cursor column.
- cursor_row_i  in  5  Cursor row.
- pixel_o  out  1  Pixel on (1) / off (0).
- active_o  out  1  active_i delayed to align with pixel_o.

## Operation
- Pipeline has 5 stages. Each stage carries a valid bit (active), x[2:0], y[3:0], and a cursor-hit flag.
- S1:
  - When active_i=1, text_addr_o <= (vcount_i[8:4] * COLS) + hcount_i[9:3]. The multiply by 80 is implemented as (r<<6)+(r<<4) and zero-extended to 12 bits.
  - When active_i=0, text_addr_o holds its value.
  - cursor_hit = cursor_en_i & (hcount_i[9:3]==cursor_col_i) & (vcount_i[8:4]==cursor_row_i).
- S2: waits on the text-buffer read; sideband is delayed.
- S3:
  - If S2 is valid, font_addr_o <= {text_data_i[6:0], y[3:0]}; text_data_i[7] is ignored.
  - Otherwise font_addr_o holds.
- S4: waits on the font read; sideband is delayed.
- S5 (output):
  - Load condition: x[2:0]==0, or S5 was invalid in the previous cycle. The latter covers the first pixel after blanking or reset.
  - On load: pixel bit = font_data_i[x[2:0]], and shreg <= font_data_i.
  - Otherwise: pixel bit = shreg[x[2:0]], and shreg holds.
  - pixel_o <= valid & (bit ^ (cursor_hit & blink_phase)).
  - active_o <= S4 valid.
- Blink:
  - Frame start is a sampled cycle with active_i=1, hcount_i=0 and vcount_i=0.
  - On each frame start, frame_cnt increments. At BLINK_FRAMES-1 it wraps to 0 and blink_phase toggles.
- Reset values:
  - text_addr_o = 0, font_addr_o = 0, pixel_o = 0, active_o = 0.
  - All valid bits = 0, shreg = 0.
  - frame_cnt = 0, blink_phase = 1 (cursor visible).

## Timing
- Coordinates presented in cycle n produce pixel_o/active_o in cycle n+5. The latency is constant and there is no stall or backpressure.
- text_addr_o is valid in n+1 and font_addr_o in n+3. Both memories have exactly 1-cycle registered-read latency.
- Pixel position requirements:
  - hcount_i must advance by 1 per cycle while active.
  - A line may start mid-character: the load-on-invalid rule still indexes the correct bit.
- Outside the visible area:
  - pixel_o = 0 whenever active_o = 0.
  - Addresses freeze while inactive, so memories see no spurious new addresses.
- Cursor inputs are sampled in S1. A change in cycle n affects pixel_o from n+5.
- Reset mid-line:
  - All outputs are at reset values the cycle after rst_i is sampled high, and in-flight pixels are discarded.
  - After release, the first valid pixel appears 5 cycles after the first active sample.
- Frame start coinciding with reset: reset wins, and no count is taken.

## Test plan
- Address math: active, hcount=24, vcount=37 -> text_addr_o=163 (row 2 x 80 + col 3) in n+1. hcount=639, vcount=479 -> 2399.
- Glyph path:
  - Stimulus: text_data_i=0x41 at cell (0,0), vcount=5, and font model returns 8'b00011000 for address {0x41,5}=1045.
  - Required: font_addr_o=1045. For hcount 0..7, pixel_o=0,0,0,1,1,0,0,0 in cycles n+5..n+12.
- Bit 7 and blanking:
  - text_data_i=0xC1 gives the same font_addr_o as 0x41.
  - active_i dropped for 10 cycles -> pixel_o=0 and active_o=0 exactly 5 cycles later, and both addresses held.
- Cursor blink:
  - Setup: BLINK_FRAMES=2, cursor at (3,2) on glyph row 8'b11111111, enabled.
  - Frames 0-1: pixel_o=0 across x 24..31.
  - Frames 2-3: pixel_o=1.
  - cursor_en_i=0 -> never inverted.
- Mid-character start: first active sample at hcount=5 after blanking, glyph row 8'b00000100 -> first pixel_o=1, then 0,0.
- Reset mid-line: assert rst_i for 1 cycle during active video -> next cycle pixel_o=0, active_o=0, addresses 0, blink_phase=1. Output resumes 5 cycles after the first active sample.
